seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the core's combinational ALU for the multi-cycle datapath. It accepts one operation per valid/ready handshake and registers the result together with Z/N/C/V flags. It adds shifts, SLT, NOR and an iterative shift-add multiplier. Output backpressure is supported, so the block can feed a stalled writeback stage without dropping results.

Parameters:
WIDTH, 64, operand and result width in bits (WIDTH >= 8, power of 2)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL executes as ADD
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount taken from b[SHW-1:0])
ALUControl  in  4  opcode
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  registered result
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
carry  out  1  carry/no-borrow flag
overflow  out  1  signed overflow flag
busy  out  1  multiply in progress

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 SLL, 1001 SRL, 1010 SRA, 0011 MUL (low WIDTH bits, unsigned). Any other opcode executes as ADD.
- Reset: state IDLE; result, all flags, out_valid and busy = 0. in_ready is forced to 0 while reset is high. Reset during a MUL abandons the multiply; no result is produced.
- Accept: a request is accepted when in_valid && in_ready.
- in_ready = !reset && state==IDLE && (!out_valid || out_ready). A new request may be accepted in the same cycle the previous result is taken.
- Single-cycle ops: result and flags are registered on the accept edge, so out_valid rises 1 cycle after accept.
- MUL: FSM IDLE -> MUL -> IDLE.
  - On accept, latch a and b, clear the accumulator, load counter = WIDTH, set busy=1.
  - Each MUL cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; counter--.
  - When counter reaches 0, write acc to result, set out_valid, clear busy, return to IDLE.
  - Latency is WIDTH+1 cycles from accept to out_valid.
- Output hold: result and flags stay stable while out_valid && !out_ready. out_valid clears on out_valid && out_ready unless a new single-cycle op is accepted in the same cycle; in that case out_valid stays 1 with the new data.
- Flags:
  - zero and negative are derived from the registered result for every op.
  - ADD: carry = unsigned carry-out; overflow = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
  - SUB: carry = 1 when a >= b unsigned (no borrow); overflow = (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
  - SLT: computed via the SUB datapath as N xor V of a-b; carry and overflow reported as 0.
  - All other ops: carry = 0, overflow = 0.
- Shifts: amount is b[SHW-1:0]; SRA replicates a[WIDTH-1]; amount 0 passes a through unchanged.
- Inputs are ignored when in_ready=0; a, b and ALUControl need only be stable in the accept cycle.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL), FSM state encoding (ST_IDLE, ST_MUL), flag-bit index constants.
- One sub-module, seq_mul: the iterative multiplier holding mcand/mplier/acc/counter, with a start/done interface. It is instantiated only when MUL_EN=1.

Test Plan:
- Reset with in_valid=1 -> in_ready=0 and all outputs 0. First cycle after reset -> in_ready=1.
- ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> next cycle result=0, zero=1, carry=1, overflow=0, out_valid=1.
- SUB a=64'h8000_0000_0000_0000, b=1 -> result=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1, negative=0. SLT a=-3, b=2 -> result=1.
- MUL a=12345, b=6789 -> busy=1 and in_ready=0 for 64 cycles, out_valid at cycle 65, result=83810205. Reset asserted at cycle 30 of a second MUL -> no out_valid; IDLE on the next cycle.
- Backpressure: OR a=8'hF0, b=8'h0F with out_ready=0 for 5 cycles -> result held at 8'hFF, in_ready=0. When out_ready rises together with a new AND request -> back-to-back accept, new result the following cycle.
- Shifts: SRA a=64'h8000_0000_0000_0000, b=63 -> all ones. SLL b=64 (amount field 0) -> result=a. Opcode 4'b1111 -> behaves as ADD.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU.
// Opcodes, FSM states and flag-bit positions.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int NFLAGS = 4;

    function automatic logic [NFLAGS-1:0] pack_flags(
        input logic z,
        input logic n,
        input logic c,
        input logic v
    );
        logic [NFLAGS-1:0] f;
        f = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU.
// master drives requests, slave is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, result,
        input  zero, negative, carry, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, result,
        output zero, negative, carry, overflow, busy
    );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier, one bit per cycle.
// done is high for one cycle once all bits are consumed.
module seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             active;

    // Load on start, then one add/shift step per cycle until count hits 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CW'(WIDTH);
            active <= 1'b1;
        end else if (active) begin
            if (count != '0) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign done    = active && (count == '0);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and flags.
// Single-cycle ops land next cycle; MUL runs iteratively.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int MUL_EN = 1
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    state_t            state;
    logic [WIDTH-1:0]  result;
    logic [NFLAGS-1:0] flags;
    logic              out_valid;
    logic              busy;

    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic              add_v;
    logic              sub_v;
    logic [SHW-1:0]    sh;
    logic [WIDTH-1:0]  nres;
    logic              nc;
    logic              nv;
    logic [NFLAGS-1:0] nflags;

    assign bus.in_ready = !reset && (state == ST_IDLE)
                        && (!out_valid || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = (MUL_EN != 0) && (bus.ALUControl == OP_MUL);

    // Single-cycle datapath; unknown opcodes (and MUL when disabled) add.
    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        diff  = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        add_v = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
        sub_v = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
        sh    = bus.b[SHW-1:0];
        nres  = sum[WIDTH-1:0];
        nc    = sum[WIDTH];
        nv    = add_v;
        unique case (1'b1)
            bus.ALUControl == OP_AND: begin
                nres = bus.a & bus.b;
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_OR: begin
                nres = bus.a | bus.b;
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_NOR: begin
                nres = ~(bus.a | bus.b);
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_SUB: begin
                nres = diff[WIDTH-1:0];
                nc = diff[WIDTH];
                nv = sub_v;
            end
            bus.ALUControl == OP_SLT: begin
                nres = {{(WIDTH-1){1'b0}}, diff[M] ^ sub_v};
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_SLL: begin
                nres = bus.a << sh;
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_SRL: begin
                nres = bus.a >> sh;
                nc = 1'b0;
                nv = 1'b0;
            end
            bus.ALUControl == OP_SRA: begin
                nres = $unsigned($signed(bus.a) >>> sh);
                nc = 1'b0;
                nv = 1'b0;
            end
            default: ;
        endcase
        nflags = pack_flags(nres == '0, nres[M], nc, nv);
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (accept && is_mul),
                .a       (bus.a),
                .b       (bus.b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Control FSM and output registers; results hold until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (out_valid && bus.out_ready) out_valid <= 1'b0;
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                        end else begin
                            result    <= nres;
                            flags     <= nflags;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        flags     <= pack_flags(mul_product == '0,
                                                mul_product[M],
                                                1'b0, 1'b0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.zero      = flags[FLAG_Z];
    assign bus.negative  = flags[FLAG_N];
    assign bus.carry     = flags[FLAG_C];
    assign bus.overflow  = flags[FLAG_V];
    assign bus.busy      = busy;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=64.
// Hand-computed vectors checked with immediate assertions.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MSB1 = {1'b1, {(W-1){1'b0}}};

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    int   n;
    int   bad;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op1(input logic [3:0] op,
                       input logic [W-1:0] av,
                       input logic [W-1:0] bv);
        bus.ALUControl = op;
        bus.a          = av;
        bus.b          = bv;
        bus.in_valid   = 1'b1;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        bus.ALUControl = OP_ADD;
        bus.a          = ONES;
        bus.b          = 64'd1;
        tick();
        tick();
        chk("rst_in_ready", W'(bus.in_ready), 0);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", W'({bus.zero, bus.negative,
                             bus.carry, bus.overflow}), 0);
        chk("rst_busy", W'(bus.busy), 0);

        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(bus.in_ready), 1);

        tick();
        chk("add_wrap_res", bus.result, 0);
        chk("add_wrap_zcv", W'({bus.zero, bus.carry, bus.overflow}),
            3'b110);
        chk("add_wrap_valid", W'(bus.out_valid), 1);

        op1(OP_SUB, MSB1, 64'd1);
        chk("sub_ovf_res", bus.result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf_ncv", W'({bus.negative, bus.carry, bus.overflow}),
            3'b011);

        op1(OP_SUB, 64'd1, 64'd2);
        chk("sub_borrow_res", bus.result, ONES);
        chk("sub_borrow_nc", W'({bus.negative, bus.carry}), 2'b10);

        op1(OP_SLT, -64'sd3, 64'd2);
        chk("slt_true", bus.result, 1);
        chk("slt_cv", W'({bus.carry, bus.overflow}), 0);

        op1(OP_SLT, 64'd2, -64'sd3);
        chk("slt_false", bus.result, 0);
        chk("slt_false_z", W'(bus.zero), 1);

        op1(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_ovf_res", bus.result, MSB1);
        chk("add_ovf_ncv", W'({bus.negative, bus.carry, bus.overflow}),
            3'b101);

        op1(OP_MUL, 64'd12345, 64'd6789);
        bus.in_valid = 1'b0;
        chk("mul_busy", W'(bus.busy), 1);
        chk("mul_in_ready", W'(bus.in_ready), 0);
        n   = 0;
        bad = 0;
        while (!bus.out_valid && n < 200) begin
            if (!bus.busy || bus.in_ready) bad++;
            tick();
            n++;
        end
        chk("mul_latency", W'(n), 65);
        chk("mul_busy_hold", W'(bad), 0);
        chk("mul_res", bus.result, 64'd83810205);
        chk("mul_done_busy", W'(bus.busy), 0);

        op1(OP_MUL, 64'd3, 64'd5);
        bus.in_valid = 1'b0;
        repeat (29) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mulrst_valid", W'(bus.out_valid), 0);
        chk("mulrst_busy", W'(bus.busy), 0);
        chk("mulrst_idle", W'(bus.in_ready), 1);
        bad = 0;
        repeat (70) begin
            tick();
            if (bus.out_valid) bad++;
        end
        chk("mulrst_no_result", W'(bad), 0);

        bus.out_ready = 1'b0;
        op1(OP_OR, 64'hF0, 64'h0F);
        bus.ALUControl = OP_AND;
        bus.a = 64'hFF;
        bus.b = 64'h3C;
        bad = 0;
        repeat (5) begin
            if (bus.result !== 64'hFF || bus.in_ready !== 1'b0
                || bus.out_valid !== 1'b1) bad++;
            tick();
        end
        chk("bp_hold", W'(bad), 0);
        chk("bp_res", bus.result, 64'hFF);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", W'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_res", bus.result, 64'h3C);
        chk("b2b_valid", W'(bus.out_valid), 1);
        tick();
        chk("b2b_drain", W'(bus.out_valid), 0);

        op1(OP_SRA, MSB1, 64'd63);
        chk("sra_ones", bus.result, ONES);
        chk("sra_neg", W'(bus.negative), 1);
        op1(OP_SRL, MSB1, 64'd4);
        chk("srl", bus.result, 64'h0800_0000_0000_0000);
        op1(OP_SLL, 64'h1234, 64'd64);
        chk("sll_amt0", bus.result, 64'h1234);
        op1(OP_SLL, 64'h1234, 64'd4);
        chk("sll4", bus.result, 64'h12340);
        op1(OP_NOR, 64'h0, 64'h0);
        chk("nor", bus.result, ONES);
        op1(4'b1111, 64'd5, 64'd7);
        chk("op_default_add", bus.result, 64'd12);
        bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
